// File: rtl/thor2025_regfile_wrsched_if.sv
// ============================================================================
// Module   : thor2025_regfile_wrsched_if
// Brief    : Requester bus and register-file write-port bus of the scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface thor2025_regfile_wrsched_if #(
    parameter int WID  = 64,
    parameter int RBIT = 11,
    parameter int NREQ = 4
);
    logic                     flush;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*(RBIT+1)-1:0] req_wa;
    logic [NREQ*8-1:0]        req_we;
    logic [NREQ*WID-1:0]      req_data;

    logic                     wr0, wr1, wr2;
    logic [7:0]               we0, we1, we2;
    logic [RBIT:0]            wa0, wa1, wa2;
    logic [WID-1:0]           i0, i1, i2;
    logic [31:0]              stall_cnt;

    modport master (
        output flush, req_valid, req_wa, req_we, req_data,
        input  req_ready,
        input  wr0, wr1, wr2, we0, we1, we2, wa0, wa1, wa2, i0, i1, i2,
        input  stall_cnt
    );

    modport slave (
        input  flush, req_valid, req_wa, req_we, req_data,
        output req_ready,
        output wr0, wr1, wr2, we0, we1, we2, wa0, wa1, wa2, i0, i1, i2,
        output stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/thor2025_regfile_wrsched.sv
// ============================================================================
// Module   : thor2025_regfile_wrsched
// Brief    : Round-robin scheduler of held FU result writes onto 3 RF write ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

module thor2025_regfile_wrsched #(
    parameter int WID  = 64,
    parameter int RBIT = 11,
    parameter int NREQ = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    thor2025_regfile_wrsched_if.slave     bus
);
    localparam int AW    = RBIT + 1;
    localparam int PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NPORT = 3;

    logic [AW-1:0]    w_req_wa   [NREQ];
    logic [7:0]       w_req_we   [NREQ];
    logic [WID-1:0]   w_req_data [NREQ];

    logic [NREQ-1:0]  r_hold_valid;
    logic [AW-1:0]    r_hold_wa   [NREQ];
    logic [7:0]       r_hold_we   [NREQ];
    logic [WID-1:0]   r_hold_data [NREQ];
    logic [PTRW-1:0]  r_rr_ptr;

    logic [NREQ-1:0]  w_grant;
    logic [NREQ-1:0]  w_accept;
    logic [NPORT-1:0] w_port_en;
    logic [PTRW-1:0]  w_port_idx [NPORT];
    logic [PTRW-1:0]  w_rr_next;
    logic             w_stall;

    logic [NPORT-1:0] r_wr;
    logic [7:0]       r_we [NPORT];
    logic [AW-1:0]    r_wa [NPORT];
    logic [WID-1:0]   r_i  [NPORT];
    logic [31:0]      r_stall_cnt;

    for (genvar n = 0; n < NREQ; n++) begin : g_unpack
        assign w_req_wa[n]   = bus.req_wa[n*AW +: AW];
        assign w_req_we[n]   = bus.req_we[n*8 +: 8];
        assign w_req_data[n] = bus.req_data[n*WID +: WID];
    end

    // Arbitration looks only at holding state, so ready never depends on valid.
    always_comb begin : p_arb
        int              idx;
        int              nsel;
        logic            clash;
        logic [PTRW-1:0] sidx;
        w_grant   = '0;
        w_port_en = '0;
        for (int p = 0; p < NPORT; p++) w_port_idx[p] = '0;
        w_rr_next = r_rr_ptr;
        idx   = 0;
        nsel  = 0;
        clash = 1'b0;
        sidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx   = (int'(r_rr_ptr) + k) % NREQ;
            sidx  = PTRW'(idx);
            clash = 1'b0;
            for (int p = 0; p < NPORT; p++) begin
                if (p < nsel && r_hold_wa[w_port_idx[p]] == r_hold_wa[sidx])
                    clash = 1'b1;
            end
            if (r_hold_valid[sidx]) begin
                // Writes to r0 or with no byte enables retire without a port.
                if (r_hold_wa[sidx][5:0] == 6'd0 || r_hold_we[sidx] == 8'd0) begin
                    w_grant[sidx] = 1'b1;
                    w_rr_next     = PTRW'((idx + 1) % NREQ);
                end else if (nsel < NPORT && !clash) begin
                    w_grant[sidx] = 1'b1;
                    for (int p = 0; p < NPORT; p++) begin
                        if (p == nsel) begin
                            w_port_en[p]  = 1'b1;
                            w_port_idx[p] = sidx;
                        end
                    end
                    nsel      = nsel + 1;
                    w_rr_next = PTRW'((idx + 1) % NREQ);
                end
            end
        end
        if (bus.flush) begin
            w_grant   = '0;
            w_port_en = '0;
            w_rr_next = r_rr_ptr;
        end
    end

    assign bus.req_ready = {NREQ{~rst & ~bus.flush}} & (~r_hold_valid | w_grant);
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign w_stall       = ~bus.flush & (|(r_hold_valid & ~w_grant));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= '0;
            r_rr_ptr     <= '0;
            for (int n = 0; n < NREQ; n++) begin
                r_hold_wa[n]   <= '0;
                r_hold_we[n]   <= '0;
                r_hold_data[n] <= '0;
            end
        end else begin
            r_rr_ptr <= w_rr_next;
            for (int n = 0; n < NREQ; n++) begin
                if (bus.flush) begin
                    r_hold_valid[n] <= 1'b0;
                end else if (w_accept[n]) begin
                    r_hold_valid[n] <= 1'b1;
                    r_hold_wa[n]    <= w_req_wa[n];
                    r_hold_we[n]    <= w_req_we[n];
                    r_hold_data[n]  <= w_req_data[n];
                end else if (w_grant[n]) begin
                    r_hold_valid[n] <= 1'b0;
                end
            end
        end
    end

    // Idle ports drop enables but keep address/data to limit RF input toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr        <= '0;
            r_stall_cnt <= '0;
            for (int p = 0; p < NPORT; p++) begin
                r_we[p] <= '0;
                r_wa[p] <= '0;
                r_i[p]  <= '0;
            end
        end else begin
            r_wr <= w_port_en;
            for (int p = 0; p < NPORT; p++) begin
                if (w_port_en[p]) begin
                    r_we[p] <= r_hold_we[w_port_idx[p]];
                    r_wa[p] <= r_hold_wa[w_port_idx[p]];
                    r_i[p]  <= r_hold_data[w_port_idx[p]];
                end else begin
                    r_we[p] <= '0;
                end
            end
            if (w_stall && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.wr0       = r_wr[0];
    assign bus.wr1       = r_wr[1];
    assign bus.wr2       = r_wr[2];
    assign bus.we0       = r_we[0];
    assign bus.we1       = r_we[1];
    assign bus.we2       = r_we[2];
    assign bus.wa0       = r_wa[0];
    assign bus.wa1       = r_wa[1];
    assign bus.wa2       = r_wa[2];
    assign bus.i0        = r_i[0];
    assign bus.i1        = r_i[1];
    assign bus.i2        = r_i[2];
    assign bus.stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_thor2025_regfile_wrsched.sv
// ============================================================================
// Module   : tb_thor2025_regfile_wrsched
// Brief    : Directed bench with a port-write scoreboard for the write scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_thor2025_regfile_wrsched;
    localparam int WID  = 64;
    localparam int RBIT = 11;
    localparam int NREQ = 4;

    typedef struct {
        int          port;
        logic [11:0] wa;
        logic [7:0]  we;
        logic [63:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];
    exp_t mon_e;

    thor2025_regfile_wrsched_if #(.WID(WID), .RBIT(RBIT), .NREQ(NREQ)) bus ();

    thor2025_regfile_wrsched #(.WID(WID), .RBIT(RBIT), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        mwr [3];
    logic [11:0] mwa [3];
    logic [7:0]  mwe [3];
    logic [63:0] mi  [3];
    assign mwr[0] = bus.wr0;  assign mwr[1] = bus.wr1;  assign mwr[2] = bus.wr2;
    assign mwa[0] = bus.wa0;  assign mwa[1] = bus.wa1;  assign mwa[2] = bus.wa2;
    assign mwe[0] = bus.we0;  assign mwe[1] = bus.we1;  assign mwe[2] = bus.we2;
    assign mi[0]  = bus.i0;   assign mi[1]  = bus.i1;   assign mi[2]  = bus.i2;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_wa    = '0;
        bus.req_we    = '0;
        bus.req_data  = '0;
    endtask

    task automatic drive_req(input int n, input logic [11:0] wa, input logic [7:0] we,
                             input logic [63:0] d);
        bus.req_valid[n]          = 1'b1;
        bus.req_wa[n*12 +: 12]    = wa;
        bus.req_we[n*8 +: 8]      = we;
        bus.req_data[n*64 +: 64]  = d;
    endtask

    task automatic push(input int port, input logic [11:0] wa, input logic [7:0] we,
                        input logic [63:0] d);
        exp_t e;
        e.port = port;
        e.wa   = wa;
        e.we   = we;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Every enabled port write must match the next expected write, in port order.
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 3; p++) begin
                if (mwr[p]) begin
                    if (sb_q.size() == 0) begin
                        check("sb_spurious_wr", 128'(mwr[p]), 128'(0));
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("sb_port", 128'(p), 128'(mon_e.port));
                        check("sb_wa", 128'(mwa[p]), 128'(mon_e.wa));
                        check("sb_we", 128'(mwe[p]), 128'(mon_e.we));
                        check("sb_data", 128'(mi[p]), 128'(mon_e.data));
                    end
                end
            end
            if (mwr[0] && mwr[1]) check("same_wa_p01", 128'(mwa[0] == mwa[1]), 128'(0));
            if (mwr[0] && mwr[2]) check("same_wa_p02", 128'(mwa[0] == mwa[2]), 128'(0));
            if (mwr[1] && mwr[2]) check("same_wa_p12", 128'(mwa[1] == mwa[2]), 128'(0));
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.flush = 1'b0;
        clear_reqs();

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b000));
        check("rst_ready", 128'(bus.req_ready), 128'(4'h0));
        check("rst_stall", 128'(bus.stall_cnt), 128'(0));
        check("rst_we0", 128'(bus.we0), 128'(0));
        check("rst_wa0", 128'(bus.wa0), 128'(0));
        check("rst_i0", 128'(bus.i0), 128'(0));
        rst = 1'b0;
        #1;
        check("ready_after_rst", 128'(bus.req_ready), 128'(4'hF));

        // Four-way contention from rr_ptr=0
        for (int n = 0; n < 4; n++) drive_req(n, 12'(n + 1), 8'hFF, 64'(32'h100 + n));
        push(0, 12'h001, 8'hFF, 64'h100);
        push(1, 12'h002, 8'hFF, 64'h101);
        push(2, 12'h003, 8'hFF, 64'h102);
        push(0, 12'h004, 8'hFF, 64'h103);
        step();
        check("c4_ready", 128'(bus.req_ready), 128'(4'b0111));
        clear_reqs();
        step();
        check("c4_wr_c1", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b111));
        check("c4_wa0_c1", 128'(bus.wa0), 128'(12'h001));
        check("c4_wa1_c1", 128'(bus.wa1), 128'(12'h002));
        check("c4_wa2_c1", 128'(bus.wa2), 128'(12'h003));
        check("c4_stall_c1", 128'(bus.stall_cnt), 128'(1));
        step();
        check("c4_wr_c2", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b100));
        check("c4_wa0_c2", 128'(bus.wa0), 128'(12'h004));
        check("c4_stall_c2", 128'(bus.stall_cnt), 128'(1));
        step();
        step();

        // Single write from requester 1
        drive_req(1, 12'h00A, 8'hFF, 64'h1234);
        push(0, 12'h00A, 8'hFF, 64'h1234);
        step();
        clear_reqs();
        step();
        check("sw_wr", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b100));
        check("sw_wa0", 128'(bus.wa0), 128'(12'h00A));
        check("sw_i0", 128'(bus.i0), 128'(64'h1234));
        check("sw_we0", 128'(bus.we0), 128'(8'hFF));
        step();

        // Write to r0 alias is discarded
        drive_req(3, 12'h040, 8'hFF, 64'hDEAD);
        step();
        check("r0_ready", 128'(bus.req_ready), 128'(4'hF));
        clear_reqs();
        step();
        check("r0_wr", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b000));
        check("r0_stall", 128'(bus.stall_cnt), 128'(1));
        step();
        check("r0_wr_late", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b000));

        // Same-address deferral from rr_ptr=0
        drive_req(0, 12'h005, 8'hFF, 64'hA0);
        drive_req(2, 12'h005, 8'h0F, 64'hA2);
        push(0, 12'h005, 8'hFF, 64'hA0);
        push(0, 12'h005, 8'h0F, 64'hA2);
        step();
        check("sa_ready", 128'(bus.req_ready), 128'(4'b1011));
        clear_reqs();
        step();
        check("sa_wr_c1", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b100));
        check("sa_i0_c1", 128'(bus.i0), 128'(64'hA0));
        check("sa_stall", 128'(bus.stall_cnt), 128'(2));
        step();
        check("sa_wr_c2", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b100));
        check("sa_i0_c2", 128'(bus.i0), 128'(64'hA2));
        check("sa_wa0_c2", 128'(bus.wa0), 128'(12'h005));
        step();

        // Flush discards three held writes
        drive_req(0, 12'h010, 8'hFF, 64'hF0);
        drive_req(1, 12'h011, 8'hFF, 64'hF1);
        drive_req(2, 12'h012, 8'hFF, 64'hF2);
        step();
        clear_reqs();
        bus.flush = 1'b1;
        #1;
        check("fl_ready_during", 128'(bus.req_ready), 128'(4'h0));
        step();
        bus.flush = 1'b0;
        check("fl_wr", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b000));
        #1;
        check("fl_ready_after", 128'(bus.req_ready), 128'(4'hF));
        check("fl_stall", 128'(bus.stall_cnt), 128'(2));
        step();
        check("fl_wr_late", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b000));

        // Reset while holds 0 and 2 are valid
        drive_req(0, 12'h020, 8'hFF, 64'hC0);
        drive_req(2, 12'h022, 8'hFF, 64'hC2);
        step();
        clear_reqs();
        rst = 1'b1;
        #1;
        check("mr_wr", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b000));
        check("mr_ready", 128'(bus.req_ready), 128'(4'h0));
        check("mr_stall", 128'(bus.stall_cnt), 128'(0));
        check("mr_wa0", 128'(bus.wa0), 128'(0));
        step();
        step();
        rst = 1'b0;
        #1;
        check("mr_ready_rel", 128'(bus.req_ready), 128'(4'hF));
        step();
        check("mr_wr_rel", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b000));
        drive_req(1, 12'h030, 8'hFF, 64'hBEEF);
        push(0, 12'h030, 8'hFF, 64'hBEEF);
        step();
        clear_reqs();
        step();
        check("mr_first_wr", 128'({bus.wr0, bus.wr1, bus.wr2}), 128'(3'b100));
        check("mr_first_wa0", 128'(bus.wa0), 128'(12'h030));
        check("mr_first_stall", 128'(bus.stall_cnt), 128'(0));

        for (int c = 0; c < 20 && sb_q.size() != 0; c++) step();
        check("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/thor2025_regfile_wrsched.md
Name: thor2025_regfile_wrsched

Overview:
- Write-port scheduler for the Thor2025 3-write/10-read register file.
- Collects result writes from NREQ functional-unit requesters, each with a single-entry holding register.
- Each cycle, assigns up to three of the held writes to register-file write ports 0..2 in round-robin order, avoiding same-address collisions within a cycle.
- Drives registered wrN/weN/waN/iN signals straight into the register file.

Parameters:
- WID, 64, data width of a register write.
- RBIT, 11, MSB index of the register address (address width RBIT+1).
- NREQ, 4, number of requesters (legal range 3..8).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard all held writes (pipeline flush)
- req_valid  in  NREQ  requester n presents a write
- req_ready  out  NREQ  requester n write accepted this cycle
- req_wa  in  NREQ*(RBIT+1)  write address, requester n at slice n
- req_we  in  NREQ*8  byte enables, requester n at slice n
- req_data  in  NREQ*WID  write data, requester n at slice n
- wr0, wr1, wr2  out  1 each  write-port enables to the register file
- we0, we1, we2  out  8 each  byte enables
- wa0, wa1, wa2  out  RBIT+1 each  write addresses
- i0, i1, i2  out  WID each  write data
- stall_cnt  out  32  saturating count of cycles in which at least one held write was not granted

Behaviour:
- Reset: hold_valid all 0; rr_ptr=0; wr0..2=0; we/wa/i=0; stall_cnt=0; req_ready=0 while rst is asserted.
- Holding registers: hold_valid[n], hold_wa[n], hold_we[n], hold_data[n].
- Handshake:
  - req_ready[n] = ~flush & (~hold_valid[n] | grant[n]).
  - Transfer occurs when req_valid[n] & req_ready[n]; the payload is captured into hold n at the clock edge.
  - grant depends only on holding state, so there is no combinational valid-to-ready path.
- Discarded writes: a held write with hold_wa[5:0]==0 (r0) or hold_we==0 is discarded. It counts as granted, frees the hold, consumes no port and does not count toward stall_cnt.
- Arbitration (combinational from hold state):
  - Scan requesters in order rr_ptr, rr_ptr+1, … mod NREQ.
  - Skip any non-valid entry.
  - Skip any entry whose full address equals the address of an entry already selected this cycle. It stays held.
  - Select at most 3 entries. The 1st selected goes to port 0, the 2nd to port 1, the 3rd to port 2.
- Port outputs: registered, one cycle after the grant. Unused ports get wrN=0 and weN=0; waN/iN hold their previous values.
- Latency:
  - A write accepted in cycle T is held at edge T.
  - It is granted no earlier than cycle T+1 and appears on a port in cycle T+2.
  - Throughput is one write per requester per cycle when uncontended.
- rr_ptr: on any grant, next rr_ptr = (index of last entry scanned and granted) + 1 mod NREQ. With no grant, rr_ptr is unchanged.
- flush:
  - At the edge: hold_valid clears, no grants are issued that cycle, and wr0..2 go to 0 next cycle.
  - A port write already registered (from the previous cycle's grant) still completes.
  - flush takes priority over new acceptance.
- stall_cnt: increments when any hold_valid entry is not granted and flush=0. It saturates at 0xFFFFFFFF.
- Ordering: one requester's writes retire in acceptance order (single entry). No ordering is guaranteed across requesters. Same-address writes never share a cycle, so the register file's live-value table sees no intra-cycle collisions.

Test Plan:
- Reset mid-traffic:
  - Stimulus: assert rst while holds 0 and 2 are valid.
  - Required: all wr*=0 and req_ready=0 immediately; after release, first accept → port write two cycles later; stall_cnt=0.
- Single write:
  - Stimulus: requester 1 writes wa=0x00A, we=0xFF, data=0x1234.
  - Required: 2 cycles later wr0=1, wa0=0x00A, i0=0x1234; wr1=wr2=0.
- Four-way contention:
  - Stimulus: all 4 requesters valid with distinct addresses 0x01..0x04, rr_ptr=0.
  - Required: cycle 1 grants req0→p0, req1→p1, req2→p2; rr_ptr=3.
  - Required: cycle 2 grants req3→p0; stall_cnt=1.
- Same-address deferral:
  - Stimulus: req0 and req2 both wa=0x005, rr_ptr=0.
  - Required: req0 is granted on port 0; req2 is held one extra cycle and then issues on port 0; never two ports with wa=0x005 in one cycle.
- r0 discard:
  - Stimulus: req3 writes wa=0x040 (low 6 bits 0).
  - Required: req_ready[3] returns 1 next cycle; no wr asserted; stall_cnt unchanged.
- Flush:
  - Stimulus: 3 holds valid, flush asserted for 1 cycle.
  - Required: no port writes on the following cycle; hold_valid=0; req_ready=0 during flush and 1 afterwards.
